// File: rtl/scb_32.sv
// In-order issue scoreboard: tracks in-flight register writes in a writeback
// slot shift register, stalls on RAW/WAW/writeback-port hazards, drives RF write.
module scb_32_slot #(
  parameter int RW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_alloc,
  input  logic [RW-1:0] i_alloc_reg,
  input  logic          i_up_v,
  input  logic [RW-1:0] i_up_r,
  output logic          o_v,
  output logic [RW-1:0] o_r
);
  // The hazard logic guarantees the slot above is empty whenever we allocate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_v <= 1'b0;
      o_r <= '0;
    end else if (i_alloc) begin
      o_v <= 1'b1;
      o_r <= i_alloc_reg;
    end else begin
      o_v <= i_up_v;
      o_r <= i_up_r;
    end
  end
endmodule

module scb_32 #(
  parameter int NUM_REG  = 32,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 3,
  localparam int REG_SELECT = $clog2(NUM_REG),
  localparam int MAX_LAT    = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [REG_SELECT-1:0] i_select_a,
  input  logic [REG_SELECT-1:0] i_select_b,
  input  logic [REG_SELECT-1:0] i_select_c,
  input  logic                  i_is_write,
  input  logic                  i_is_load,
  input  logic                  i_is_store,
  output logic                  o_stall,
  output logic                  o_issue,
  output logic                  o_wb_valid,
  output logic [REG_SELECT-1:0] o_wb_reg,
  output logic                  o_busy,
  output logic [15:0]           o_stall_cnt
);
  logic [MAX_LAT:1]                 slot_v;
  logic [MAX_LAT:1][REG_SELECT-1:0] slot_r;
  logic [MAX_LAT:1]                 alloc;
  logic pend_a, pend_b, pend_c, port_busy;
  logic wr_tracked, use_c, raw, waw, port;
  int   lat;

  assign wr_tracked = i_is_write & (i_select_a != '0);
  assign use_c      = ~i_is_load & ~i_is_store;

  // Slot 1 is excluded from pending: the RF writes through in that cycle.
  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    pend_c = 1'b0;
    for (int k = 2; k <= MAX_LAT; k++) begin
      if (slot_v[k] && slot_r[k] == i_select_a) pend_a = 1'b1;
      if (slot_v[k] && slot_r[k] == i_select_b) pend_b = 1'b1;
      if (slot_v[k] && slot_r[k] == i_select_c) pend_c = 1'b1;
    end
  end

  always_comb begin
    lat       = i_is_load ? LOAD_LAT : ALU_LAT;
    port_busy = 1'b0;
    for (int k = 1; k < MAX_LAT; k++)
      if (lat == k) port_busy = slot_v[k+1];
  end

  assign raw     = pend_b | (use_c & pend_c) | (i_is_store & pend_a);
  assign waw     = wr_tracked & pend_a;
  assign port    = wr_tracked & port_busy;
  assign o_stall = i_valid & (raw | waw | port);
  assign o_issue = i_valid & ~o_stall;

  always_comb begin
    alloc = '0;
    for (int k = 1; k <= MAX_LAT; k++)
      alloc[k] = o_issue & wr_tracked & (lat == k);
  end

  for (genvar k = 1; k <= MAX_LAT; k++) begin : g_slot
    logic                  up_v;
    logic [REG_SELECT-1:0] up_r;
    if (k == MAX_LAT) begin : g_top
      assign up_v = 1'b0;
      assign up_r = '0;
    end else begin : g_mid
      assign up_v = slot_v[k+1];
      assign up_r = slot_r[k+1];
    end
    scb_32_slot #(.RW(REG_SELECT)) u_slot (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_alloc     (alloc[k]),
      .i_alloc_reg (i_select_a),
      .i_up_v      (up_v),
      .i_up_r      (up_r),
      .o_v         (slot_v[k]),
      .o_r         (slot_r[k])
    );
  end

  assign o_wb_valid = slot_v[1];
  assign o_wb_reg   = slot_r[1];
  assign o_busy     = |slot_v;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                            o_stall_cnt <= '0;
    else if (o_stall && ~&o_stall_cnt)    o_stall_cnt <= o_stall_cnt + 16'd1;
  end
endmodule
